cordic_out_stage: RTL and testbench
===================================

# cordic_out_stage

Output stage that sits directly downstream of the 6-iteration pipelined CORDIC rotator. It tracks sample validity and a quadrant-flip flag through the rotator's 5 pipeline registers. It applies CORDIC gain compensation and quadrant correction to the rotator's tail x/y, then buffers results in a small FIFO with a valid/ready output handshake. It owns the rotator's register enable and stalls the rotator when the FIFO cannot accept more results.

## Interface
Parameters:
- `DATA_W`, 16: width of x/y/angle, signed two's complement Q8.8.
- `PIPE_DEPTH`, 5: number of rotator register stages to track.
- `FIFO_DEPTH`, 4: output buffer entries, power of two.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `issue_valid`  in  1  a new sample is presented at the rotator input this cycle.
- `issue_neg`  in  1  the sample's target angle was pre-folded by 180°; negate the results.
- `issue_ready`  out  1  equals `pipe_en`; upstream holds the sample while low.
- `pipe_en`  out  1  drives the rotator's `reg_en`.
- `x_in`, `y_in`, `angle_in`  in  DATA_W  rotator tail outputs (combinational from its last register).
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry.
- `cos_out`, `sin_out`, `res_out`  out  DATA_W  head entry: corrected x, corrected y, residual angle.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- `pipe_en = (fifo_level < FIFO_DEPTH)`. It is combinational from registered state only; it never depends on `out_ready` in the same cycle.
- Accept: `issue_valid & pipe_en` at an edge loads `vld[0]=1` and `neg[0]=issue_neg`. Otherwise `vld[0]=0` when `pipe_en` is high.
- When `pipe_en` is high, `vld/neg[k]` shift to `[k+1]` each edge. When `pipe_en` is low, the whole tracker holds.
- Write: on an edge with `pipe_en & vld[PIPE_DEPTH-1]`, the tail result is pushed into the FIFO.
- Tail datapath (combinational before the FIFO):
  - Gain step: g(v) = (v>>>1)+(v>>>3)−(v>>>6)−(v>>>9)−(v>>>12), K≈0.60718. Shifts are arithmetic and truncating. Sums are computed at DATA_W+2 bits, then saturated to DATA_W.
  - Negate step: if `neg`, the result is −g(v), saturated. −(−32768) gives 32767.
  - `res_out` is `angle_in` unmodified.
- Pop: `out_valid & out_ready` removes the head.
- A simultaneous push and pop leaves the level unchanged. A push while full cannot occur because `pipe_en` is low.
- Reset clears `vld`, `neg`, the FIFO pointers and `fifo_level`. The rotator's data registers are not reset. Any in-flight samples are discarded, and stale rotator data is never pushed because `vld` is clear.

## Timing
- Reset values: `out_valid=0`, `fifo_level=0`, `pipe_en=1`, `issue_ready=1`, `cos_out/sin_out/res_out=0`.
- With `pipe_en` held high, a sample accepted at edge E0 is pushed at edge E5. `out_valid` rises in the cycle after E5.
- FIFO outputs are registered head entries; the FIFO has no fall-through.
- Throughput is one sample per cycle while `out_ready` stays high.
- When the FIFO is full, `pipe_en` drops in the same cycle `fifo_level` reaches FIFO_DEPTH. It rises in the cycle after the next pop.
- Pointers wrap modulo FIFO_DEPTH.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined: gain step as above.
- `CORDIC_GAIN_COMP_EN` undefined: the gain step is identity (g(v)=v). Upstream is expected to pre-scale `x_init` by K. Latency is unchanged.

## Structure
- Shared package `cordic_pkg` holds:
  - DATA_W, PIPE_DEPTH;
  - the angle LUT constants (45°=0x2D00, 26.57°=0x1A90, 14.04°=0x0E09, 7.13°=0x0720, 3.58°=0x0393, 1.79°=0x01CA);
  - the gain shift list {1,3,6,9,12} with signs.
- One sub-module, `cordic_out_fifo`: a synchronous FIFO with level output and registered head.

## Test plan
- **Single sample, compensation on:** issue x_in=0x0100, y_in=0, neg=0, out_ready=1 → at E5+1, out_valid=1, cos_out=0x009C, sin_out=0x0000.
- **Quadrant flip:** same sample with neg=1 → cos_out=0xFF64. Then x_in=0x8000 with compensation off and neg=1 → 0x7FFF (saturated).
- **Backpressure:** out_ready=0, issue every cycle → after 4 pushes fifo_level=4 and pipe_en=0. The tracker holds. Pop one → exactly one further push. No sample is lost or duplicated (sequence check on res_out).
- **Bubbles:** issue on alternate cycles → out_valid pattern matches the issue pattern shifted by 6 cycles.
- **Reset mid-flight:** 3 samples in flight, rst_n low for 1 cycle → no out_valid afterward, fifo_level=0, pipe_en=1.
- **Compensation off:** x_in=0x0100 → cos_out=0x0100.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the 6-iteration CORDIC rotator and its output stage:
// default widths, the arctangent LUT, and the gain-compensation shift list.
package cordic_pkg;

  localparam int DATA_W     = 16;
  localparam int PIPE_DEPTH = 5;
  localparam int N_ITER     = 6;

  // atan(2^-i) in Q8.8 degrees
  localparam logic [15:0] ANGLE_LUT [N_ITER] = '{
    16'h2D00, 16'h1A90, 16'h0E09, 16'h0720, 16'h0393, 16'h01CA
  };

  // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12
  localparam int          GAIN_N            = 5;
  localparam int unsigned GAIN_SHIFT [GAIN_N] = '{1, 3, 6, 9, 12};
  localparam bit          GAIN_NEG   [GAIN_N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/cordic_out_fifo.sv
// Synchronous FIFO with occupancy output and a registered head entry
// (no fall-through: a push into an empty FIFO is visible the next cycle).
module cordic_out_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             pop;

  assign valid   = (count != '0);
  assign pop     = valid & ready;
  assign rd_next = rd_ptr + AW'(pop);
  assign dout    = head;
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Head mirrors mem[rd_ptr]; when the incoming entry becomes the new head
  // it is taken straight from din because mem is written on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_next;
      count  <= count + LW'(push) - LW'(pop);
      if (push && (wr_ptr == rd_next)) head <= din;
      else if (pop)                    head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/cordic_out_stage.sv
// CORDIC output stage: validity/negate tracking, gain compensation, quadrant
// correction and output FIFO. Define CORDIC_GAIN_COMP_EN to enable the gain step.
module cordic_out_stage
  import cordic_pkg::*;
#(
  parameter int DATA_W     = cordic_pkg::DATA_W,
  parameter int PIPE_DEPTH = cordic_pkg::PIPE_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic                        issue_neg,
  output logic                        issue_ready,
  output logic                        pipe_en,
  input  logic [DATA_W-1:0]           x_in,
  input  logic [DATA_W-1:0]           y_in,
  input  logic [DATA_W-1:0]           angle_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           cos_out,
  output logic [DATA_W-1:0]           sin_out,
  output logic [DATA_W-1:0]           res_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int EXT_W = DATA_W + 2;

  logic [PIPE_DEPTH-1:0] vld, neg;
  logic [LVL_W-1:0]      level;
  logic                  push;
  logic [DATA_W-1:0]     cos_c, sin_c;

  function automatic logic [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] v);
    if ((v[EXT_W-1:DATA_W-1] == '0) || (v[EXT_W-1:DATA_W-1] == '1))
      return v[DATA_W-1:0];
    else if (v[EXT_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic [DATA_W-1:0] correct(input logic [DATA_W-1:0] v,
                                                input logic n);
    logic signed [EXT_W-1:0] ext, acc;
    logic [DATA_W-1:0]       g;
    ext = {{2{v[DATA_W-1]}}, v};
`ifdef CORDIC_GAIN_COMP_EN
    acc = '0;
    for (int unsigned i = 0; i < GAIN_N; i++) begin
      if (GAIN_NEG[i]) acc = acc - (ext >>> GAIN_SHIFT[i]);
      else             acc = acc + (ext >>> GAIN_SHIFT[i]);
    end
`else
    acc = ext;
`endif
    g = sat(acc);
    if (n) begin
      acc = -{{2{g[DATA_W-1]}}, g};
      return sat(acc);
    end
    return g;
  endfunction

  assign pipe_en     = (level < LVL_W'(FIFO_DEPTH));
  assign issue_ready = pipe_en;
  assign fifo_level  = level;
  assign push        = pipe_en & vld[PIPE_DEPTH-1];

  // Tracker shares the rotator's enable so tags stay aligned with its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      neg <= '0;
    end else if (pipe_en) begin
      vld <= {vld[PIPE_DEPTH-2:0], issue_valid};
      neg <= {neg[PIPE_DEPTH-2:0], issue_neg};
    end
  end

  assign cos_c = correct(x_in, neg[PIPE_DEPTH-1]);
  assign sin_c = correct(y_in, neg[PIPE_DEPTH-1]);

  cordic_out_fifo #(
    .WIDTH (3 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({cos_c, sin_c, angle_in}),
    .ready (out_ready),
    .valid (out_valid),
    .dout  ({cos_out, sin_out, res_out}),
    .level (level)
  );

endmodule

// File: tb/tb_cordic_out_stage.sv
// Bench for cordic_out_stage: identity-rotator model driven by pipe_en, plus an
// in-order scoreboard of expected results computed with integer arithmetic.
module tb_cordic_out_stage;

  logic        clk = 1'b0;
  logic        rst_n, issue_valid, issue_neg, out_ready;
  logic        issue_ready, pipe_en, out_valid;
  logic [15:0] ix, iy, ia;
  logic [15:0] x_in, y_in, angle_in;
  logic [15:0] cos_out, sin_out, res_out;
  logic [2:0]  fifo_level;

  logic [15:0] rx [5];
  logic [15:0] ry [5];
  logic [15:0] ra [5];
  logic [47:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [15:0] E_100  = 16'h009C;
  localparam logic [15:0] E_100N = 16'hFF64;
  localparam logic [15:0] E_8000N = 16'h4DB8;
`else
  localparam logic [15:0] E_100  = 16'h0100;
  localparam logic [15:0] E_100N = 16'hFF00;
  localparam logic [15:0] E_8000N = 16'h7FFF;
`endif

  always #5 clk = ~clk;

  cordic_out_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_neg   (issue_neg),
    .issue_ready (issue_ready),
    .pipe_en     (pipe_en),
    .x_in        (x_in),
    .y_in        (y_in),
    .angle_in    (angle_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cos_out     (cos_out),
    .sin_out     (sin_out),
    .res_out     (res_out),
    .fifo_level  (fifo_level)
  );

  // Rotator stand-in: five enabled delay registers, no reset.
  always @(posedge clk) begin
    if (pipe_en) begin
      rx[0] <= ix; ry[0] <= iy; ra[0] <= ia;
      for (int k = 1; k < 5; k++) begin
        rx[k] <= rx[k-1]; ry[k] <= ry[k-1]; ra[k] <= ra[k-1];
      end
    end
  end
  assign x_in     = rx[4];
  assign y_in     = ry[4];
  assign angle_in = ra[4];

  function automatic int fdiv(int v, int n);
    int d;
    d = 1 << n;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int clamp(int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] ref_xy(logic [15:0] v, logic n);
    int s, g;
    s = int'($signed(v));
`ifdef CORDIC_GAIN_COMP_EN
    g = fdiv(s, 1) + fdiv(s, 3) - fdiv(s, 6) - fdiv(s, 9) - fdiv(s, 12);
`else
    g = s;
`endif
    g = clamp(g);
    if (n) g = clamp(-g);
    return 16'(g);
  endfunction

  // One clock: scoreboard at negedge, inputs change #1 after posedge.
  task automatic cyc();
    logic [47:0] e;
    @(negedge clk);
    if (!rst_n) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected got res=%h want no entry", res_out);
        end else begin
          e = exp_q.pop_front();
          if ({cos_out, sin_out, res_out} !== e) begin
            n_fail++;
            $display("FAIL sb_entry got %h_%h_%h want %h_%h_%h",
                     cos_out, sin_out, res_out, e[47:32], e[31:16], e[15:0]);
          end
        end
      end
      if (issue_valid && pipe_en)
        exp_q.push_back({ref_xy(ix, issue_neg), ref_xy(iy, issue_neg), ia});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    ix = 16'($urandom()); iy = 16'($urandom()); issue_neg = 1'($urandom());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0; issue_neg = 1'b0; out_ready = 1'b0;
    ix = '0; iy = '0; ia = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    n_tests++; if (pipe_en !== 1'b1 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_en got %b%b want 11", pipe_en, issue_ready); end
    n_tests++; if ({cos_out, sin_out, res_out} !== 48'h0) begin n_fail++; $display("FAIL rst_data got %h_%h_%h want 0", cos_out, sin_out, res_out); end
  endtask

  task automatic test_single(input string nm, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] a, input logic n, input logic [15:0] ec,
                             input logic [15:0] es);
    out_ready = 1'b1; ix = x; iy = y; ia = a; issue_neg = n; issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early at E%0d got 1 want 0", nm, k); end
    end
    cyc();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b want 1", nm, out_valid); end
    n_tests++; if (cos_out !== ec) begin n_fail++; $display("FAIL %s_cos got %h want %h", nm, cos_out, ec); end
    n_tests++; if (sin_out !== es) begin n_fail++; $display("FAIL %s_sin got %h want %h", nm, sin_out, es); end
    n_tests++; if (res_out !== a) begin n_fail++; $display("FAIL %s_res got %h want %h", nm, res_out, a); end
    cyc();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_pop got %b want 0", nm, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] next_a;
    logic        acc;
    next_a = 16'h0100;
    out_ready = 1'b0; issue_valid = 1'b1; ia = next_a; rand_data();
    for (int i = 0; i < 15; i++) begin
      acc = pipe_en;
      cyc();
      if (acc) begin next_a++; ia = next_a; rand_data(); end
      if (i >= 11) begin
        n_tests++; if (fifo_level !== 3'd4 || pipe_en !== 1'b0) begin n_fail++; $display("FAIL bp_full got lvl=%0d en=%b want 4,0", fifo_level, pipe_en); end
      end
    end
    n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", issue_ready); end
    n_tests++; if (res_out !== 16'h0100) begin n_fail++; $display("FAIL bp_head got %h want 0100", res_out); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_tests++; if (fifo_level !== 3'd3 || pipe_en !== 1'b1) begin n_fail++; $display("FAIL bp_pop got lvl=%0d en=%b want 3,1", fifo_level, pipe_en); end
    n_tests++; if (res_out !== 16'h0101) begin n_fail++; $display("FAIL bp_head2 got %h want 0101", res_out); end
    for (int i = 0; i < 4; i++) begin
      acc = pipe_en;
      cyc();
      if (acc) begin next_a++; ia = next_a; rand_data(); end
      n_tests++; if (fifo_level !== 3'd4 || pipe_en !== 1'b0) begin n_fail++; $display("FAIL bp_refill got lvl=%0d en=%b want 4,0", fifo_level, pipe_en); end
    end
    issue_valid = 1'b0; out_ready = 1'b1;
    repeat (20) cyc();
    n_tests++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got left=%0d valid=%b want 0,0", exp_q.size(), out_valid); end
  endtask

  task automatic test_bubbles();
    logic iss [40];
    logic ov  [40];
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ov[c]  = out_valid;
      iss[c] = (c < 20) && (c % 2 == 0);
      issue_valid = iss[c]; ia = 16'(16'h2000 + c); rand_data();
      cyc();
    end
    issue_valid = 1'b0;
    for (int c = 0; c < 34; c++) begin
      n_tests++; if (ov[c+6] !== iss[c]) begin n_fail++; $display("FAIL bubble_c%0d got %b want %b", c + 6, ov[c+6], iss[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int nv, nstall;
    nv = 0; nstall = 0;
    out_ready = 1'b1; issue_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 20) issue_valid = 1'b0;
      ia = 16'(16'h3000 + c); rand_data();
      if (out_valid) nv++;
      if (!pipe_en) nstall++;
      cyc();
    end
    n_tests++; if (nv != 20) begin n_fail++; $display("FAIL b2b_count got %0d want 20", nv); end
    n_tests++; if (nstall != 0) begin n_fail++; $display("FAIL b2b_stall got %0d want 0", nstall); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; issue_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin ia = 16'(16'h4000 + c); rand_data(); cyc(); end
    issue_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid c%0d got 1 want 0", c); end
      cyc();
    end
    n_tests++; if (fifo_level !== 3'd0 || pipe_en !== 1'b1) begin n_fail++; $display("FAIL midrst_state got lvl=%0d en=%b want 0,1", fifo_level, pipe_en); end
  endtask

  task automatic test_random();
    logic [15:0] next_a;
    logic        acc;
    next_a = 16'h5000; ia = next_a; rand_data(); issue_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(issue_valid && !pipe_en)) issue_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      acc = issue_valid & pipe_en;
      cyc();
      if (acc) begin next_a++; ia = next_a; rand_data(); end
    end
    issue_valid = 1'b0; out_ready = 1'b1;
    repeat (20) cyc();
    n_tests++; if (exp_q.size() != 0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL rand_drain got left=%0d lvl=%0d want 0,0", exp_q.size(), fifo_level); end
  endtask

  initial begin
    test_reset();
    test_single("single", 16'h0100, 16'h0000, 16'h1234, 1'b0, E_100, 16'h0000);
    test_single("neg",    16'h0100, 16'h0000, 16'h1235, 1'b1, E_100N, 16'h0000);
    test_single("negmin", 16'h8000, 16'h0000, 16'h1236, 1'b1, E_8000N, 16'h0000);
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
